// File: rtl/shifter_pkg.sv
// shifter_pkg
// Shared constants and helpers for the ARM-style barrel shifter.
//   SH_LSL/SH_LSR/SH_ASR/SH_ROR : shift type encoding of shift_control[1:0]
//   OP_IMM/OP_REG               : operand source select, shift_control[2]
//   ror32()                     : 32-bit rotate right by 0..31
package shifter_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic OP_IMM = 1'b0;
  localparam logic OP_REG = 1'b1;

  // Rotate through a doubled copy so a zero amount needs no special case.
  function automatic logic [31:0] ror32(input logic [31:0] value,
                                        input logic [4:0]  amt);
    logic [63:0] doubled;
    doubled = {value, value} >> amt;
    return doubled[31:0];
  endfunction

endpackage

// File: rtl/imm_rotator.sv
// imm_rotator
// Combinational rotated-immediate operand: zero-extends an 8-bit immediate
// and rotates it right by twice the rotation field.
// Ports:
//   imm           in  8  immediate byte
//   rotation_code in  4  rotate field (rotation = 2 * rotation_code)
//   carry_in      in  1  current C flag, passed through for a zero rotation
//   value         out 32 rotated operand
//   carry         out 1  shifter carry
module imm_rotator
  import shifter_pkg::*;
(
  input  logic [7:0]  imm,
  input  logic [3:0]  rotation_code,
  input  logic        carry_in,
  output logic [31:0] value,
  output logic        carry
);

  logic [4:0] rot_amt;

  assign rot_amt = {rotation_code, 1'b0};
  assign value   = ror32({24'd0, imm}, rot_amt);

  // A non-zero rotation leaves its last rotated-out bit in bit 31.
  assign carry = (rotation_code == 4'd0) ? carry_in : value[31];

endmodule

// File: rtl/arm_barrel_shifter.sv
// arm_barrel_shifter
// Registered 32-bit ARM-style barrel shifter producing the second ALU operand
// and the shifter carry. Operand is either a rotated 8-bit immediate or a
// register shifted LSL/LSR/ASR/ROR/RRX by an immediate or register amount.
// Optional feature macro: SHIFTER_RRX_EN (immediate ROR #0 performs RRX;
// when undefined, ROR #0 passes in_data and carry_in through).
// Ports:
//   clk           in  1  rising-edge clock
//   rst           in  1  synchronous active-high reset (priority over enable)
//   enable        in  1  capture new result this edge
//   in_data       in  32 register operand
//   in_data_imm   in  8  immediate operand byte
//   imm_or_reg    in  1  1: amount = shift_amt_imm, 0: amount = shift_amt_reg[7:0]
//   shift_control in  3  [2] operand source, [1:0] shift type
//   shift_amt_imm in  5  immediate shift amount
//   shift_amt_reg in  32 register shift amount (bits [7:0] used)
//   rotation_code in  4  immediate rotate field
//   carry_in      in  1  current C flag
//   carry_out     out 1  registered shifter carry
//   out_data      out 32 registered shifted operand
module arm_barrel_shifter
  import shifter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] in_data,
  input  logic [7:0]  in_data_imm,
  input  logic        imm_or_reg,
  input  logic [2:0]  shift_control,
  input  logic [4:0]  shift_amt_imm,
  input  logic [31:0] shift_amt_reg,
  input  logic [3:0]  rotation_code,
  input  logic        carry_in,
  output logic        carry_out,
  output logic [31:0] out_data
);

  logic [31:0] imm_val;
  logic        imm_carry;

  logic [7:0]  amt_reg;
  logic [7:0]  amt_eff;
  logic        amt_zero;
  logic [1:0]  sh_type;

  logic [32:0] lsl_w;
  logic [32:0] lsr_w;
  logic [32:0] asr_w;
  logic [31:0] ror_v;

  logic [31:0] reg_val;
  logic        reg_carry;
  logic [31:0] nxt_val;
  logic        nxt_carry;

  logic        unused_amt_hi;

  assign unused_amt_hi = ^shift_amt_reg[31:8];

  imm_rotator u_imm_rotator (
    .imm           (in_data_imm),
    .rotation_code (rotation_code),
    .carry_in      (carry_in),
    .value         (imm_val),
    .carry         (imm_carry)
  );

  assign sh_type = shift_control[1:0];
  assign amt_reg = shift_amt_reg[7:0];

  // An immediate amount of 0 encodes #32 for LSR/ASR; LSL #0 and ROR #0 are
  // resolved separately below via amt_zero, so they never see the 32.
  assign amt_zero = imm_or_reg ? (shift_amt_imm == 5'd0) : (amt_reg == 8'd0);
  assign amt_eff  = imm_or_reg ? ((shift_amt_imm == 5'd0) ? 8'd32 : {3'd0, shift_amt_imm})
                               : amt_reg;

  // 33-bit shifts carry the last shifted-out bit alongside the result, which
  // also yields the #32 and >32 corner cases without extra compares:
  //   lsl_w = {carry, value}, lsr_w/asr_w = {value, carry}.
  assign lsl_w = {1'b0, in_data} << amt_eff;
  assign lsr_w = {in_data, 1'b0} >> amt_eff;
  assign asr_w = $signed({in_data, 1'b0}) >>> amt_eff;

  // Rotation by r[4:0]; r a non-zero multiple of 32 rotates by 0 and the
  // carry still comes out as bit 31, matching the ARM rule.
  assign ror_v = ror32(in_data, amt_eff[4:0]);

  always_comb begin
    reg_val   = in_data;
    reg_carry = carry_in;
    case (sh_type)
      SH_LSL: begin
        if (!amt_zero) begin
          {reg_carry, reg_val} = lsl_w;
        end
      end
      SH_LSR: begin
        if (!amt_zero || imm_or_reg) begin
          {reg_val, reg_carry} = lsr_w;
        end
      end
      SH_ASR: begin
        if (!amt_zero || imm_or_reg) begin
          {reg_val, reg_carry} = asr_w;
        end
      end
      default: begin
        if (!amt_zero) begin
          reg_val   = ror_v;
          reg_carry = ror_v[31];
        end else if (imm_or_reg) begin
`ifdef SHIFTER_RRX_EN
          reg_val   = {carry_in, in_data[31:1]};
          reg_carry = in_data[0];
`else
          reg_val   = in_data;
          reg_carry = carry_in;
`endif
        end
      end
    endcase
  end

  always_comb begin
    nxt_val   = reg_val;
    nxt_carry = reg_carry;
    if (shift_control[2] == OP_IMM) begin
      nxt_val   = imm_val;
      nxt_carry = imm_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= 32'd0;
      carry_out <= 1'b0;
    end else if (enable) begin
      out_data  <= nxt_val;
      carry_out <= nxt_carry;
    end
  end

endmodule

// File: tb/tb_arm_barrel_shifter.sv
module tb_arm_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] in_data;
  logic [7:0]  in_data_imm;
  logic        imm_or_reg;
  logic [2:0]  shift_control;
  logic [4:0]  shift_amt_imm;
  logic [31:0] shift_amt_reg;
  logic [3:0]  rotation_code;
  logic        carry_in;
  logic        carry_out;
  logic [31:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_val;
  logic        exp_c;

  always #5 clk = ~clk;

  arm_barrel_shifter dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .in_data       (in_data),
    .in_data_imm   (in_data_imm),
    .imm_or_reg    (imm_or_reg),
    .shift_control (shift_control),
    .shift_amt_imm (shift_amt_imm),
    .shift_amt_reg (shift_amt_reg),
    .rotation_code (rotation_code),
    .carry_in      (carry_in),
    .carry_out     (carry_out),
    .out_data      (out_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Rotate right one bit at a time, straight from the definition.
  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
    return r;
  endfunction

  // Reference: returns {carry, value} following the ARM operand-2 rules.
  function automatic logic [32:0] ref_model(
    input logic [31:0] d, input logic [7:0] imm, input logic ior,
    input logic [2:0] sc, input logic [4:0] ai, input logic [31:0] ar,
    input logic [3:0] rc, input logic cin);
    logic [31:0] v;
    logic        c;
    int          n;
    logic        s;
    s = d[31];
    v = d;
    c = cin;
    if (!sc[2]) begin
      v = rotr({24'd0, imm}, 2 * int'(rc));
      c = (rc == 0) ? cin : v[31];
    end else if (ior) begin
      n = int'(ai);
      case (sc[1:0])
        2'b00: if (n != 0) begin v = d << n; c = d[32-n]; end
        2'b01: if (n == 0) begin v = 0; c = s; end
               else begin v = d >> n; c = d[n-1]; end
        2'b10: if (n == 0) begin v = {32{s}}; c = s; end
               else begin v = $signed(d) >>> n; c = d[n-1]; end
        default: begin
          if (n == 0) begin
`ifdef SHIFTER_RRX_EN
            v = {cin, d[31:1]}; c = d[0];
`else
            v = d; c = cin;
`endif
          end else begin
            v = rotr(d, n); c = d[n-1];
          end
        end
      endcase
    end else begin
      n = int'(ar[7:0]);
      if (n != 0) begin
        case (sc[1:0])
          2'b00: if (n < 32) begin v = d << n; c = d[32-n]; end
                 else if (n == 32) begin v = 0; c = d[0]; end
                 else begin v = 0; c = 0; end
          2'b01: if (n < 32) begin v = d >> n; c = d[n-1]; end
                 else if (n == 32) begin v = 0; c = s; end
                 else begin v = 0; c = 0; end
          2'b10: if (n < 32) begin v = $signed(d) >>> n; c = d[n-1]; end
                 else begin v = {32{s}}; c = s; end
          default: if (n % 32 == 0) begin v = d; c = s; end
                   else begin v = rotr(d, n % 32); c = d[(n % 32) - 1]; end
        endcase
      end
    end
    return {c, v};
  endfunction

  task automatic cycle_and_check(input string tag);
    logic [32:0] m;
    m = ref_model(in_data, in_data_imm, imm_or_reg, shift_control,
                  shift_amt_imm, shift_amt_reg, rotation_code, carry_in);
    if (rst) begin
      exp_val = 32'd0; exp_c = 1'b0;
    end else if (enable) begin
      exp_val = m[31:0]; exp_c = m[32];
    end
    @(posedge clk);
    #1;
    check({tag, "_val"}, out_data, exp_val);
    check({tag, "_c"}, {31'd0, carry_out}, {31'd0, exp_c});
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] d, input logic [7:0] imm, input logic ior,
                       input logic [2:0] sc, input logic [4:0] ai, input logic [31:0] ar,
                       input logic [3:0] rc, input logic cin);
    in_data = d; in_data_imm = imm; imm_or_reg = ior; shift_control = sc;
    shift_amt_imm = ai; shift_amt_reg = ar; rotation_code = rc; carry_in = cin;
  endtask

  task automatic directed(input string tag, input logic [31:0] want_v, input logic want_c);
    cycle_and_check(tag);
    check({tag, "_const_val"}, out_data, want_v);
    check({tag, "_const_c"}, {31'd0, carry_out}, {31'd0, want_c});
  endtask

  logic [31:0] amt_r;

  initial begin
    exp_val = 32'd0;
    exp_c   = 1'b0;
    rst     = 1'b1;
    enable  = 1'b1;
    drive(32'hFFFF_FFFF, 8'hFF, 1'b1, 3'b111, 5'd3, 32'd5, 4'd3, 1'b1);
    @(negedge clk);
    cycle_and_check("reset_with_enable");

    rst = 1'b0;
    enable = 1'b0;
    drive(32'h1234_5678, 8'h5A, 1'b1, 3'b100, 5'd1, 32'd1, 4'd0, 1'b1);
    cycle_and_check("reset_hold");

    enable = 1'b1;
    carry_in = 1'b0;
    drive(32'h8000_0009, 8'h00, 1'b1, 3'b100, 5'd2, 32'd0, 4'd0, 1'b0);
    directed("lsl_imm2", 32'h0000_0024, 1'b0);

    drive(32'h8000_0009, 8'h00, 1'b0, 3'b100, 5'd0, 32'd2, 4'd0, 1'b0);
    directed("lsl_reg2", 32'h0000_0024, 1'b0);

    drive(32'h8000_0009, 8'h00, 1'b0, 3'b100, 5'd0, 32'd33, 4'd0, 1'b0);
    directed("lsl_reg33", 32'h0000_0000, 1'b0);

    drive(32'h8000_0009, 8'h00, 1'b0, 3'b100, 5'd0, 32'd32, 4'd0, 1'b0);
    directed("lsl_reg32", 32'h0000_0000, 1'b1);

    drive(32'h8000_0009, 8'h00, 1'b1, 3'b110, 5'd4, 32'd0, 4'd0, 1'b0);
    directed("asr_imm4", 32'hF800_0000, 1'b1);

    drive(32'h8000_0009, 8'h00, 1'b1, 3'b110, 5'd0, 32'd0, 4'd0, 1'b0);
    directed("asr_imm32", 32'hFFFF_FFFF, 1'b1);

    drive(32'h8000_0009, 8'h00, 1'b1, 3'b101, 5'd0, 32'd0, 4'd0, 1'b0);
    directed("lsr_imm32", 32'h0000_0000, 1'b1);

    drive(32'h8000_0009, 8'h00, 1'b1, 3'b111, 5'd0, 32'd0, 4'd0, 1'b1);
`ifdef SHIFTER_RRX_EN
    directed("rrx", 32'hC000_0004, 1'b1);
`else
    directed("ror0_passthru", 32'h8000_0009, 1'b1);
`endif

    drive(32'h8000_0009, 8'h00, 1'b0, 3'b111, 5'd0, 32'd64, 4'd0, 1'b0);
    directed("ror_reg64", 32'h8000_0009, 1'b1);

    drive(32'h0000_0000, 8'hB8, 1'b1, 3'b000, 5'd7, 32'd9, 4'd1, 1'b1);
    directed("imm_rot1", 32'h0000_002E, 1'b0);

    drive(32'h0000_0000, 8'hB8, 1'b1, 3'b000, 5'd7, 32'd9, 4'd0, 1'b1);
    directed("imm_rot0", 32'h0000_00B8, 1'b1);

    drive(32'h0000_0000, 8'h03, 1'b1, 3'b000, 5'd0, 32'd0, 4'd1, 1'b0);
    directed("imm_wrap", 32'hC000_0000, 1'b1);

    enable = 1'b0;
    drive(32'hDEAD_BEEF, 8'h11, 1'b0, 3'b101, 5'd9, 32'd3, 4'd2, 1'b0);
    cycle_and_check("enable_low_hold");

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: amt_r = 32'($urandom_range(0, 40));
        1: amt_r = {$urandom, 8'($urandom_range(224, 255))} >> 8;
        2: amt_r = {24'($urandom), 8'd32};
        default: amt_r = $urandom;
      endcase
      drive($urandom, 8'($urandom), 1'($urandom), 3'($urandom), 5'($urandom),
            amt_r, 4'($urandom), 1'($urandom));
      enable = ($urandom_range(0, 7) != 0);
      rst    = ($urandom_range(0, 40) == 0);
      cycle_and_check("random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
